// File: rtl/mmu_xlate_arbiter.sv
// mmu_xlate_arbiter: shares one translator (DMW/direct/TLB) and one TLB lookup
// port between instruction fetch and load/store. One translation in flight.
//
// Optional build macro: XLATE_STARVE_GUARD_EN
//   When defined, a small counter bounds the number of back-to-back data grants
//   while a fetch request is waiting (STARVE_LIMIT). When undefined, data always
//   wins over fetch.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no translation in flight; grants issued combinationally
// S_LOOKUP | translator sees vaddr_q, TLB lookup strobed
// S_WAIT   | TLB path: tlb_found valid, capture result
// S_RESP   | rvalid to the owner for one cycle, rsp_* valid

module mmu_xlate_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_vaddr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  input  logic        data_req,
  input  logic [31:0] data_vaddr,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] rsp_paddr,
  output logic [1:0]  rsp_mat,
  output logic        rsp_tlbr,
  input  logic        csr_busy,
  output logic [31:0] tr_vaddr,
  input  logic [31:0] tr_paddr,
  input  logic        tr_is_usetlb,
  input  logic [1:0]  tr_mat,
  output logic        tlb_lookup,
  output logic [18:0] tlb_vppn,
  output logic        tlb_odd,
  input  logic        tlb_found
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] vaddr_q;
  logic        owner_q;     // 1 = data owns the in-flight translation, 0 = inst
  logic        starve_hit;
  logic        grant_ok;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("mmu_xlate_arbiter: STARVE_LIMIT must be in 1..7");
  end

`ifdef XLATE_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  // Count data grants taken while fetch waits; cleared once fetch is served or stops asking.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (!inst_req || inst_gnt) begin
      starve_cnt <= 3'd0;
    end else if (data_gnt && starve_cnt != 3'd7) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // Fetch has waited through STARVE_LIMIT data grants: it takes the next slot.
  always_comb begin
    starve_hit = inst_req && (starve_cnt == 3'(STARVE_LIMIT));
  end
`else
  // Strict data priority: fetch is never promoted.
  always_comb begin
    starve_hit = 1'b0;
  end
`endif

  // Grant decision; only in IDLE, never during reset or a pending CSR write.
  always_comb begin
    grant_ok = (state == S_IDLE) && !csr_busy && !rst;
    data_gnt = grant_ok && data_req && !starve_hit;
    inst_gnt = grant_ok && inst_req && !(data_req && !starve_hit);
  end

  // Translator and TLB see the latched vaddr only while a translation is in flight.
  always_comb begin
    tr_vaddr = (state != S_IDLE) ? vaddr_q : 32'd0;
    tlb_vppn = vaddr_q[31:13];
    tlb_odd  = vaddr_q[12];
  end

  // Sequencer: latch winner, strobe lookup, capture result, pulse rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      vaddr_q     <= 32'd0;
      owner_q     <= 1'b0;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      rsp_paddr   <= 32'd0;
      rsp_mat     <= 2'd0;
      rsp_tlbr    <= 1'b0;
      tlb_lookup  <= 1'b0;
    end else begin
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      tlb_lookup  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (data_gnt || inst_gnt) begin
            vaddr_q    <= data_gnt ? data_vaddr : inst_vaddr;
            owner_q    <= data_gnt;
            tlb_lookup <= 1'b1;
            state      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!tr_is_usetlb) begin
            // DMW hit or direct mode: result is final, no need to wait on the TLB.
            rsp_paddr   <= tr_paddr;
            rsp_mat     <= tr_mat;
            rsp_tlbr    <= 1'b0;
            inst_rvalid <= !owner_q;
            data_rvalid <= owner_q;
            state       <= S_RESP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          rsp_paddr   <= tr_paddr;
          rsp_mat     <= tr_mat;
          rsp_tlbr    <= ~tlb_found;
          inst_rvalid <= !owner_q;
          data_rvalid <= owner_q;
          state       <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_xlate_arbiter.sv
// Bench for mmu_xlate_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.

module tb_mmu_xlate_arbiter;

  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic [31:0] inst_vaddr, data_vaddr;
  logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid;
  logic [31:0] rsp_paddr;
  logic [1:0]  rsp_mat;
  logic        rsp_tlbr;
  logic        csr_busy;
  logic [31:0] tr_vaddr, tr_paddr;
  logic        tr_is_usetlb;
  logic [1:0]  tr_mat;
  logic        tlb_lookup;
  logic [18:0] tlb_vppn;
  logic        tlb_odd, tlb_found;

  mmu_xlate_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid),
    .data_req(data_req), .data_vaddr(data_vaddr), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .rsp_paddr(rsp_paddr), .rsp_mat(rsp_mat), .rsp_tlbr(rsp_tlbr), .csr_busy(csr_busy),
    .tr_vaddr(tr_vaddr), .tr_paddr(tr_paddr), .tr_is_usetlb(tr_is_usetlb), .tr_mat(tr_mat),
    .tlb_lookup(tlb_lookup), .tlb_vppn(tlb_vppn), .tlb_odd(tlb_odd), .tlb_found(tlb_found)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a single in-flight transaction with its grant and response cycles.
  bit          m_busy = 1'b0;
  int          m_start, m_due;
  bit          m_owner_data;
  logic [31:0] m_vaddr, m_paddr;
  logic [1:0]  m_mat;
  logic        m_tlbr;
  int          m_streak = 0;

  always @(negedge clk) begin
    logic e_dg, e_ig, free, inflight, starve, at_resp, at_lk;
    if (cyc >= 1) begin
      inflight = m_busy && (cyc <= m_due);
      free     = !inflight;
      starve   = 1'b0;
`ifdef XLATE_STARVE_GUARD_EN
      starve   = inst_req && (m_streak == LIMIT);
`endif
      e_dg = 1'b0;
      e_ig = 1'b0;
      if (free && !csr_busy && !rst) begin
        if (starve)        e_ig = 1'b1;
        else if (data_req) e_dg = 1'b1;
        else if (inst_req) e_ig = 1'b1;
      end
      at_resp = inflight && (cyc == m_due);
      at_lk   = inflight && (cyc == m_start + 1);

      chk("data_gnt", 32'(data_gnt), 32'(e_dg));
      chk("inst_gnt", 32'(inst_gnt), 32'(e_ig));
      chk("data_rvalid", 32'(data_rvalid), 32'(at_resp && m_owner_data));
      chk("inst_rvalid", 32'(inst_rvalid), 32'(at_resp && !m_owner_data));
      if (at_resp) begin
        chk("rsp_paddr", rsp_paddr, m_paddr);
        chk("rsp_mat", 32'(rsp_mat), 32'(m_mat));
        chk("rsp_tlbr", 32'(rsp_tlbr), 32'(m_tlbr));
      end
      chk("tlb_lookup", 32'(tlb_lookup), 32'(at_lk));
      if (at_lk) begin
        chk("tlb_vppn", 32'(tlb_vppn), 32'(m_vaddr[31:13]));
        chk("tlb_odd", 32'(tlb_odd), 32'(m_vaddr[12]));
      end
      chk("tr_vaddr", tr_vaddr, (inflight && cyc > m_start) ? m_vaddr : 32'd0);
      chk("gnt_rvalid_overlap", 32'((data_gnt | inst_gnt) & (data_rvalid | inst_rvalid)), 32'd0);

      if (rst) begin
        m_busy   = 1'b0;
        m_streak = 0;
      end else begin
        if (e_dg || e_ig) begin
          m_busy       = 1'b1;
          m_start      = cyc;
          m_due        = cyc + (tr_is_usetlb ? 3 : 2);
          m_owner_data = e_dg;
          m_vaddr      = e_dg ? data_vaddr : inst_vaddr;
          m_paddr      = tr_paddr;
          m_mat        = tr_mat;
          m_tlbr       = tr_is_usetlb && !tlb_found;
        end
        if (!inst_req || e_ig) m_streak = 0;
        else if (e_dg)         m_streak++;
      end
    end
  end

  // Requester behaviour and event recording for the directed checks.
  int          data_left, inst_left;
  int          t_dg, t_ig, t_drv, t_irv, t_lk, n_gnt, n_rv, inst_pos;
  logic [31:0] cap_paddr;
  logic [1:0]  cap_mat;
  logic        cap_tlbr, cap_odd;
  logic [18:0] cap_vppn;

  task automatic clear_rec();
    t_dg = -1; t_ig = -1; t_drv = -1; t_irv = -1; t_lk = -1;
    n_gnt = 0; n_rv = 0; inst_pos = -1;
  endtask

  task automatic req(input int nd, input int ni);
    data_left = nd;
    inst_left = ni;
    data_req  = (nd > 0);
    inst_req  = (ni > 0);
  endtask

  task automatic tick();
    logic g_d, g_i;
    @(negedge clk);
    g_d = data_gnt;
    g_i = inst_gnt;
    if (g_d) begin t_dg = cyc; n_gnt++; end
    if (g_i) begin t_ig = cyc; inst_pos = n_gnt; n_gnt++; end
    if (data_rvalid || inst_rvalid) begin
      if (data_rvalid) t_drv = cyc;
      if (inst_rvalid) t_irv = cyc;
      n_rv++;
      cap_paddr = rsp_paddr;
      cap_mat   = rsp_mat;
      cap_tlbr  = rsp_tlbr;
    end
    if (tlb_lookup) begin
      t_lk     = cyc;
      cap_vppn = tlb_vppn;
      cap_odd  = tlb_odd;
    end
    @(posedge clk);
    #1;
    if (g_d && data_left > 0) data_left--;
    if (g_i && inst_left > 0) inst_left--;
    data_req = (data_left > 0);
    inst_req = (inst_left > 0);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_gnt"}, 32'(data_gnt), 32'd0);
    chk({tag, "_inst_gnt"}, 32'(inst_gnt), 32'd0);
    chk({tag, "_data_rvalid"}, 32'(data_rvalid), 32'd0);
    chk({tag, "_inst_rvalid"}, 32'(inst_rvalid), 32'd0);
    chk({tag, "_rsp_paddr"}, rsp_paddr, 32'd0);
    chk({tag, "_rsp_mat"}, 32'(rsp_mat), 32'd0);
    chk({tag, "_rsp_tlbr"}, 32'(rsp_tlbr), 32'd0);
    chk({tag, "_tlb_lookup"}, 32'(tlb_lookup), 32'd0);
    chk({tag, "_tr_vaddr"}, tr_vaddr, 32'd0);
    chk({tag, "_tlb_vppn"}, 32'(tlb_vppn), 32'd0);
  endtask

  initial begin
    int t_rel;
    rst = 1'b1;
    inst_req = 1'b0; data_req = 1'b0; inst_vaddr = 32'd0; data_vaddr = 32'd0;
    csr_busy = 1'b0; tr_paddr = 32'd0; tr_is_usetlb = 1'b0; tr_mat = 2'd0; tlb_found = 1'b0;
    data_left = 0; inst_left = 0;
    clear_rec();
    run(3);
    chk_all_zero("reset");
    rst = 1'b0;
    run(1);

    // DMW hit on the data port
    tr_is_usetlb = 1'b0; tr_paddr = 32'h1000_1234; tr_mat = 2'd1; tlb_found = 1'b0;
    data_vaddr = 32'h9000_1234;
    clear_rec();
    req(1, 0);
    run(6);
    chk("dmw_latency", 32'(t_drv - t_dg), 32'd2);
    chk("dmw_paddr", cap_paddr, 32'h1000_1234);
    chk("dmw_mat", 32'(cap_mat), 32'd1);
    chk("dmw_tlbr", 32'(cap_tlbr), 32'd0);
    chk("dmw_rv_count", 32'(n_rv), 32'd1);

    // TLB hit on the fetch port
    tr_is_usetlb = 1'b1; tr_paddr = 32'h0800_3000; tr_mat = 2'd1; tlb_found = 1'b1;
    inst_vaddr = 32'h0040_3000;
    clear_rec();
    req(0, 1);
    run(6);
    chk("tlbhit_latency", 32'(t_irv - t_ig), 32'd3);
    chk("tlbhit_lookup_cycle", 32'(t_lk - t_ig), 32'd1);
    chk("tlbhit_vppn", 32'(cap_vppn), 32'h0_0201);
    chk("tlbhit_odd", 32'(cap_odd), 32'd1);
    chk("tlbhit_paddr", cap_paddr, 32'h0800_3000);
    chk("tlbhit_tlbr", 32'(cap_tlbr), 32'd0);

    // TLB miss on the fetch port
    tlb_found = 1'b0;
    clear_rec();
    req(0, 1);
    run(6);
    chk("tlbmiss_latency", 32'(t_irv - t_ig), 32'd3);
    chk("tlbmiss_tlbr", 32'(cap_tlbr), 32'd1);

    // Contention behind a CSR write
    tr_is_usetlb = 1'b0; tr_paddr = 32'h1234_5000; tr_mat = 2'd2;
    data_vaddr = 32'h9000_0040; inst_vaddr = 32'h9000_0080;
    csr_busy = 1'b1;
    clear_rec();
    req(1, 1);
    run(2);
    chk("csr_blocks_grant", 32'(n_gnt), 32'd0);
    csr_busy = 1'b0;
    t_rel = cyc;
    run(10);
    chk("contention_data_first", 32'(t_dg), 32'(t_rel));
    chk("contention_inst_after_resp", 32'(t_ig), 32'(t_drv + 1));
    chk("contention_rv_count", 32'(n_rv), 32'd2);

    // CSR write arriving mid-translation does not abort it
    tr_is_usetlb = 1'b1; tlb_found = 1'b1; data_vaddr = 32'h0040_3000;
    clear_rec();
    req(1, 0);
    run(1);
    csr_busy = 1'b1;
    run(5);
    csr_busy = 1'b0;
    chk("csr_inflight_rv_count", 32'(n_rv), 32'd1);
    chk("csr_inflight_latency", 32'(t_drv - t_dg), 32'd3);

    // Data stream with a waiting fetch
    tr_is_usetlb = 1'b0;
    data_vaddr = 32'h9000_0100; inst_vaddr = 32'h9000_0200;
    clear_rec();
    req(3, 1);
    run(16);
    chk("stream_grant_count", 32'(n_gnt), 32'd4);
`ifdef XLATE_STARVE_GUARD_EN
    chk("starve_inst_slot", 32'(inst_pos), 32'd2);
`else
    chk("strict_inst_slot", 32'(inst_pos), 32'd3);
`endif

    // Reset during WAIT drops the translation
    tr_is_usetlb = 1'b1; tlb_found = 1'b1; tr_paddr = 32'h0800_3000;
    data_vaddr = 32'h0040_3000;
    clear_rec();
    req(1, 0);
    run(2);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk_all_zero("midreset");
    run(4);
    chk("midreset_no_rvalid", 32'(n_rv), 32'd0);
    tr_is_usetlb = 1'b0; tr_paddr = 32'h1000_0040; data_vaddr = 32'h9000_0040;
    clear_rec();
    req(1, 0);
    run(5);
    chk("rerequest_latency", 32'(t_drv - t_dg), 32'd2);
    chk("rerequest_paddr", cap_paddr, 32'h1000_0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
